uart_tx_en: RTL and testbench

- Byte-serial UART transmitter: the transmit side paired with the team's oversampled, enable-gated receiver.
- Accepts one byte through a valid/ready handshake and drives an 8N1 frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Every bit lasts Oversample enable ticks, so one baud-tick generator (one en pulse per oversample period) drives both TX and RX.
- Sits between the bus-side register block and the pad.

---
 rtl/uart_tx_en.sv | 125 ++++++++++++
 tb/tb_uart_tx_en.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_en.sv
// uart_tx_en: enable-gated 8N1 UART transmitter; each bit lasts Oversample en ticks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_en #(
    parameter int Oversample = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       done
);

    localparam int CntW = $clog2(Oversample);
    localparam logic [CntW-1:0] reloadVal = CntW'(Oversample - 1);
    localparam logic [CntW-1:0] cntOne    = CntW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, nextState;
    logic [CntW-1:0] sampleCnt, sampleNext;
    logic [3:0]      bitCnt, bitNext;
    logic [7:0]      shiftReg, shiftNext;
    logic            readyNext, outNext, doneNext;
    logic            accept, tick, boundary;
`ifdef UART_TX_PARITY_EN
    logic            parityBit, parityNext;
`endif

    // ready is high only in IDLE, so acceptance can never interrupt a frame
    assign accept   = valid && ready;
    assign tick     = en && (state != IDLE);
    assign boundary = tick && (sampleCnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sampleCnt <= reloadVal;
            bitCnt    <= 4'd8;
            shiftReg  <= 8'h00;
            ready     <= 1'b1;
            out       <= 1'b1;
            done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state     <= nextState;
            sampleCnt <= sampleNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
            ready     <= readyNext;
            out       <= outNext;
            done      <= doneNext;
`ifdef UART_TX_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

    always_comb begin
        nextState  = state;
        sampleNext = sampleCnt;
        bitNext    = bitCnt;
        shiftNext  = shiftReg;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        if (accept) begin
            nextState  = START;
            sampleNext = reloadVal;
            bitNext    = 4'd8;
            shiftNext  = data;
`ifdef UART_TX_PARITY_EN
            parityNext = ^data;
`endif
        end else if (tick) begin
            if (sampleCnt != '0) begin
                sampleNext = sampleCnt - cntOne;
            end else begin
                sampleNext = reloadVal;
                case (state)
                    START: nextState = DATA;
                    DATA: begin
                        shiftNext = {1'b0, shiftReg[7:1]};
                        bitNext   = bitCnt - 4'd1;
                        if (bitCnt == 4'd1) begin
`ifdef UART_TX_PARITY_EN
                            nextState = PARITY;
`else
                            nextState = STOP;
`endif
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: nextState = STOP;
`endif
                    STOP:    nextState = IDLE;
                    default: nextState = IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from the next state so out moves on the edge after a boundary
    always_comb begin
        readyNext = (nextState == IDLE);
        doneNext  = boundary && (state == STOP);
        case (nextState)
            START:   outNext = 1'b0;
            DATA:    outNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  outNext = parityNext;
`endif
            default: outNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_en.sv
// tb_uart_tx_en: directed checks of frame shape, timing, handshake and reset for uart_tx_en.
`timescale 1ns/1ps
module tb_uart_tx_en;

`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    int phase       = 0;

    uart_tx_en #(.Oversample(16)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Line level of each frame bit: index 0 is the start bit
    function automatic logic [10:0] frameBits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1;
            checkOutput($sformatf("idle_out[%0d]", i), out, 1'b1);
            checkOutput($sformatf("idle_ready[%0d]", i), ready, 1'b1);
            checkOutput($sformatf("idle_done[%0d]", i), done, 1'b0);
        end
    endtask

    // Called at a negedge with the transmitter idle; returns at the negedge of the done cycle
    task automatic applyStimulus(input logic [7:0] b, input int p, input bit keepValid,
                                 input logic [7:0] nextByte, input bit glitch, input int abortAt);
        int          bitLen;
        int          total;
        logic [10:0] f;
        bitLen = 16 * p;
        total  = NBits * bitLen;
        f      = frameBits(b);
        checkOutput($sformatf("pre_ready_%02h", b), ready, 1'b1);
        data  = b;
        valid = 1'b1;
        phase = 0;
        en    = 1'b1;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            phase = (phase + 1) % p;
            en    = (phase == 0);
            if (c == abortAt) begin
                reset = 1'b1;
                #1;
                checkOutput("abort_out", out, 1'b1);
                checkOutput("abort_ready", ready, 1'b1);
                checkOutput("abort_done", done, 1'b0);
                return;
            end
            if (c <= total) begin
                checkOutput($sformatf("out_%02h_c%0d", b, c), out, f[(c-1)/bitLen]);
                checkOutput($sformatf("done_%02h_c%0d", b, c), done, 1'b0);
                checkOutput($sformatf("ready_%02h_c%0d", b, c), ready, 1'b0);
            end else begin
                checkOutput($sformatf("end_out_%02h", b), out, 1'b1);
                checkOutput($sformatf("end_done_%02h", b), done, 1'b1);
                checkOutput($sformatf("end_ready_%02h", b), ready, 1'b1);
            end
            if (keepValid)
                data = (c == total + 1) ? nextByte : 8'h55;
            else
                valid = 1'b0;
            if (glitch && c == 50) begin
                valid = 1'b1;
                data  = 8'hFF;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        data  = 8'h00;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out", out, 1'b1);
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_done", done, 1'b0);
        reset = 1'b0;
        idle(3);

        $display("[TB] 0xA5 with en every cycle");
        applyStimulus(8'hA5, 1, 1'b0, 8'h00, 1'b0, 0);
        idle(4);

        $display("[TB] 0x00 with en every 4th cycle");
        applyStimulus(8'h00, 4, 1'b0, 8'h00, 1'b0, 0);
        idle(4);

        $display("[TB] back-to-back 0x3C then 0xC3");
        applyStimulus(8'h3C, 1, 1'b1, 8'hC3, 1'b0, 0);
        applyStimulus(8'hC3, 1, 1'b0, 8'h00, 1'b0, 0);
        idle(4);

        $display("[TB] valid pulse with 0xFF while busy");
        applyStimulus(8'h96, 1, 1'b0, 8'h00, 1'b1, 0);
        idle(20);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'hA5, 1, 1'b0, 8'h00, 1'b0, 70);
        @(negedge clk);
        checkOutput("held_reset_ready", ready, 1'b1);
        reset = 1'b0;
        idle(40);
        applyStimulus(8'h81, 1, 1'b0, 8'h00, 1'b0, 0);
        idle(4);

        $display("[TB] reset together with valid");
        reset = 1'b1;
        valid = 1'b1;
        data  = 8'hF0;
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        checkOutput("rstvalid_ready", ready, 1'b1);
        checkOutput("rstvalid_out", out, 1'b1);
        idle(20);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames 0x07 and 0x03");
        applyStimulus(8'h07, 1, 1'b0, 8'h00, 1'b0, 0);
        idle(4);
        applyStimulus(8'h03, 1, 1'b0, 8'h00, 1'b0, 0);
        idle(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
